// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants and state type for the SRAM port model
// Contents:
//   SRAM_ADDR_BITS / SRAM_DATA_BITS : default bus widths shared with sram_iface
//   DATA_BUS_FLOAT                  : value returned when no storage backs a read
//   sram_resp_state_t               : responder FSM states
package sram_pkg;

    localparam int SRAM_ADDR_BITS = 16;
    localparam int SRAM_DATA_BITS = 8;

    localparam logic [SRAM_DATA_BITS-1:0] DATA_BUS_FLOAT = '0;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD
    } sram_resp_state_t;

endpackage

// File: rtl/sram_mem_array.sv
// rtl/sram_mem_array.sv - DEPTH x DATA_BITS storage, synchronous write and read
// Ports:
//   clk   : clock, rising edge
//   we    : write strobe, wdata stored at addr on the edge
//   addr  : shared word index for both ports
//   wdata : write data
//   rdata : registered read data, mem[addr] captured every edge
// The storage has no reset.
module sram_mem_array #(
    parameter int DEPTH     = 256,
    parameter int DATA_BITS = 8,
    parameter int IDX_BITS  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - target-side SRAM port model with fixed access latency
// Ports:
//   clk, n_rst        : clock (rising edge), asynchronous active-low reset
//   read_enable       : read request level
//   write_enable      : write request level
//   address, w_data   : request address and write data, latched at capture
//   r_data            : registered read data, held between reads
//   ack               : one-cycle completion pulse
//   busy              : high while in ACCESS
//   addr_err          : sticky, an access completed with address >= DEPTH
//   proto_err         : sticky, both enables seen high in IDLE
//   clear_err         : synchronous clear of the sticky flags (and statistics)
//   rd_count/wr_count : acked read/write counters, only with SRAM_STATS_EN
// Optional build macro: SRAM_STATS_EN
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_BITS = SRAM_ADDR_BITS,
    parameter int DATA_BITS = SRAM_DATA_BITS,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 read_enable,
    input  logic                 write_enable,
    input  logic [ADDR_BITS-1:0] address,
    input  logic [DATA_BITS-1:0] w_data,
    output logic [DATA_BITS-1:0] r_data,
    output logic                 ack,
    output logic                 busy,
    output logic                 addr_err,
    output logic                 proto_err,
    input  logic                 clear_err
`ifdef SRAM_STATS_EN
    ,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
`endif
);

    localparam int         IDX_BITS = $clog2(DEPTH);
    localparam logic [3:0] LAT      = 4'(LATENCY);

    sram_resp_state_t state, state_next;

    logic                 op_wr;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] data_q;
    logic [3:0]           cnt;

    logic                 op_en;
    logic                 capture;
    logic                 proto_hit;
    logic                 complete;
    logic                 in_range;
    logic                 mem_we;
    logic [IDX_BITS-1:0]  mem_addr;
    logic [DATA_BITS-1:0] mem_q;

    // The enable that belongs to the latched operation; dropping it aborts.
    assign op_en     = op_wr ? write_enable : read_enable;
    assign capture   = (state == IDLE) && (read_enable ^ write_enable);
    assign proto_hit = (state == IDLE) && read_enable && write_enable;
    assign complete  = (state == ACCESS) && op_en && (cnt == LAT);

    // Full-width compare so upper address bits never alias into the array.
    assign in_range  = 32'(addr_q) < 32'(DEPTH);
    assign mem_we    = complete && op_wr && in_range;

    // The array read port is fed the live address in IDLE so that the
    // captured word is already registered by the first ACCESS cycle; this
    // keeps LATENCY=1 working with a synchronous read. No write can happen
    // while a read is in flight, so the prefetched word stays valid.
    assign mem_addr  = (state == IDLE) ? address[IDX_BITS-1:0]
                                       : addr_q[IDX_BITS-1:0];

    sram_mem_array #(
        .DEPTH     (DEPTH),
        .DATA_BITS (DATA_BITS),
        .IDX_BITS  (IDX_BITS)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (data_q),
        .rdata (mem_q)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                if (!op_en) begin
                    state_next = IDLE;
                end else if (cnt == LAT) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!read_enable && !write_enable) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            op_wr     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cnt       <= '0;
            r_data    <= '0;
            ack       <= 1'b0;
            addr_err  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            ack <= complete;

            if (capture) begin
                op_wr  <= write_enable;
                addr_q <= address;
                data_q <= w_data;
            end

            if (capture) begin
                cnt <= 4'd1;
            end else if (state_next == ACCESS) begin
                cnt <= cnt + 4'd1;
            end else begin
                cnt <= '0;
            end

            if (complete && !op_wr) begin
                r_data <= in_range ? mem_q : DATA_BITS'(DATA_BUS_FLOAT);
            end

            // A new event in the same cycle as clear_err keeps the flag set.
            addr_err  <= (complete && !in_range) | (addr_err & ~clear_err);
            proto_err <= proto_hit | (proto_err & ~clear_err);
        end
    end

`ifdef SRAM_STATS_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (clear_err) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (complete) begin
            if (op_wr && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (!op_wr && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built.
`endif

endmodule
